if_stage: RTL and testbench



---
 rtl/cpu_defs.sv | 31 +++
 rtl/if_stage_npc_sel.sv | 44 ++++
 rtl/if_stage.sv | 94 +++++++++
 tb/tb_if_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared constants and types for the pipeline front end.
package cpu_defs;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam int          IM_WORDS   = 2048;

  localparam logic [4:0]  EXC_ADEL   = 5'd4;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  // Which source the next fetch PC came from.
  typedef enum logic [1:0] {
    NPC_SEQ  = 2'd0,
    NPC_BR   = 2'd1,
    NPC_EXC  = 2'd2,
    NPC_ERET = 2'd3
  } npc_t;

  // True when a fetch from pc would fault (misaligned or outside IM).
  // The end bound is formed in 33 bits so a window touching the top of
  // the address space does not wrap to zero.
  function automatic logic fetch_fault(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input int          words);
    logic [32:0] im_end;
    im_end = {1'b0, base} + 33'(4 * words);
    return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= im_end);
  endfunction

endpackage

// File: rtl/if_stage_npc_sel.sv
// Next-PC priority mux: exception > eret > stall > branch > sequential.
module npc_sel
  import cpu_defs::*;
#(
  parameter logic [31:0] HANDLER_PC_P = HANDLER_PC
) (
  input  logic [31:0] pc_f,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] npc,
  output npc_t        sel,
  output logic        flush,
  output logic        hold
);

  // Exception and eret override a stall; a stalled cycle drops br_taken
  // because decode will present the branch again once the stall clears.
  always_comb begin
    npc   = pc_f + 32'd4;
    sel   = NPC_SEQ;
    flush = 1'b0;
    hold  = 1'b0;
    if (exc_req) begin
      npc   = HANDLER_PC_P;
      sel   = NPC_EXC;
      flush = 1'b1;
    end else if (eret_req) begin
      npc   = epc;
      sel   = NPC_ERET;
      flush = 1'b1;
    end else if (stall) begin
      npc   = pc_f;
      hold  = 1'b1;
    end else if (br_taken) begin
      npc   = br_target;
      sel   = NPC_BR;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IM addressing, IF/ID register.
module if_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC_P   = RESET_PC,
  parameter logic [31:0] HANDLER_PC_P = HANDLER_PC,
  parameter logic [31:0] IM_BASE_P    = IM_BASE,
  parameter int          IM_WORDS_P   = IM_WORDS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        bd_next,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] pc_f,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        bd_d,
  output logic        exc_d,
  output logic [4:0]  exccode_d
);

  logic [31:0] npc;
  npc_t        npc_src;
  logic        flush;
  logic        hold;
  logic        fault;

  npc_sel #(
    .HANDLER_PC_P (HANDLER_PC_P)
  ) u_npc_sel (
    .pc_f      (pc_f),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .npc       (npc),
    .sel       (npc_src),
    .flush     (flush),
    .hold      (hold)
  );

  // IM is addressed relative to its base; a faulting fetch still drives it.
  always_comb begin
    im_addr = pc_f - IM_BASE_P;
    fault   = fetch_fault(pc_f, IM_BASE_P, IM_WORDS_P);
  end

  // PC and IF/ID update; a faulting fetch becomes a nop carrying AdEL
  // while its PC, link value and delay-slot flag load normally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_f      <= RESET_PC_P;
      ir_d      <= NOP;
      pc_d      <= 32'h0;
      pc8_d     <= 32'h0;
      bd_d      <= 1'b0;
      exc_d     <= 1'b0;
      exccode_d <= 5'd0;
    end else if (flush) begin
      pc_f      <= npc;
      ir_d      <= NOP;
      pc_d      <= 32'h0;
      pc8_d     <= 32'h0;
      bd_d      <= 1'b0;
      exc_d     <= 1'b0;
      exccode_d <= 5'd0;
    end else if (!hold) begin
      pc_f      <= npc;
      pc_d      <= pc_f;
      pc8_d     <= pc_f + 32'd8;
      bd_d      <= bd_next;
      if (fault) begin
        ir_d      <= NOP;
        exc_d     <= 1'b1;
        exccode_d <= EXC_ADEL;
      end else begin
        ir_d      <= im_data;
        exc_d     <= 1'b0;
        exccode_d <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
module tb_if_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        bd_next;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic [31:0] pc_f;
  logic [31:0] ir_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        bd_d;
  logic        exc_d;
  logic [4:0]  exccode_d;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .bd_next   (bd_next),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .im_addr   (im_addr),
    .im_data   (im_data),
    .pc_f      (pc_f),
    .ir_d      (ir_d),
    .pc_d      (pc_d),
    .pc8_d     (pc8_d),
    .bd_d      (bd_d),
    .exc_d     (exc_d),
    .exccode_d (exccode_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IM model: word i holds 32'h1000_0000 + i; outside the array reads DEADBEEF.
  always_comb begin
    im_data = 32'hDEAD_BEEF;
    if (im_addr < 32'h0000_2000) im_data = 32'h1000_0000 + {2'b00, im_addr[31:2]};
  end

  // Advance one edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; br_taken = 0; br_target = 0; bd_next = 0;
    exc_req = 0; eret_req = 0; epc = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    step();
    step();
    checks++; if (pc_f !== 32'h3000) begin errors++; $display("[TB] FAIL reset_pc_f got %h exp %h", pc_f, 32'h3000); end
    checks++; if (im_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_im_addr got %h exp %h", im_addr, 32'h0); end
    checks++; if (ir_d !== 32'h0) begin errors++; $display("[TB] FAIL reset_ir_d got %h exp %h", ir_d, 32'h0); end
    checks++; if (pc_d !== 32'h0 || pc8_d !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc_d got %h/%h exp 0/0", pc_d, pc8_d); end
    checks++; if (bd_d !== 1'b0 || exc_d !== 1'b0 || exccode_d !== 5'd0) begin errors++; $display("[TB] FAIL reset_flags got %b/%b/%h exp 0/0/0", bd_d, exc_d, exccode_d); end
  endtask

  task automatic test_sequential();
    reset_n = 1;
    step();
    checks++; if (pc_f !== 32'h3004) begin errors++; $display("[TB] FAIL seq0_pc_f got %h exp %h", pc_f, 32'h3004); end
    checks++; if (ir_d !== 32'h1000_0000 || pc_d !== 32'h3000 || pc8_d !== 32'h3008) begin errors++; $display("[TB] FAIL seq0_ifid got %h/%h/%h exp 10000000/3000/3008", ir_d, pc_d, pc8_d); end
    step();
    checks++; if (pc_f !== 32'h3008) begin errors++; $display("[TB] FAIL seq1_pc_f got %h exp %h", pc_f, 32'h3008); end
    checks++; if (ir_d !== 32'h1000_0001 || pc_d !== 32'h3004 || pc8_d !== 32'h300C) begin errors++; $display("[TB] FAIL seq1_ifid got %h/%h/%h exp 10000001/3004/300c", ir_d, pc_d, pc8_d); end
    step();
    checks++; if (pc_f !== 32'h300C) begin errors++; $display("[TB] FAIL seq2_pc_f got %h exp %h", pc_f, 32'h300C); end
    checks++; if (ir_d !== 32'h1000_0002 || pc_d !== 32'h3008 || pc8_d !== 32'h3010 || exc_d !== 1'b0) begin errors++; $display("[TB] FAIL seq2_ifid got %h/%h/%h/%b exp 10000002/3008/3010/0", ir_d, pc_d, pc8_d, exc_d); end
  endtask

  task automatic test_branch();
    // pc_f = 300C here; the word at 300C is the delay slot.
    br_taken = 1; br_target = 32'h3100; bd_next = 1;
    step();
    clear_inputs();
    checks++; if (pc_f !== 32'h3100) begin errors++; $display("[TB] FAIL br_pc_f got %h exp %h", pc_f, 32'h3100); end
    checks++; if (ir_d !== 32'h1000_0003 || pc_d !== 32'h300C || bd_d !== 1'b1) begin errors++; $display("[TB] FAIL br_delay_slot got %h/%h/%b exp 10000003/300c/1", ir_d, pc_d, bd_d); end
  endtask

  task automatic test_stall();
    stall = 1; br_taken = 1; br_target = 32'h3200;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (pc_f !== 32'h3100) begin errors++; $display("[TB] FAIL stall_pc_f[%0d] got %h exp %h", i, pc_f, 32'h3100); end
      checks++; if (ir_d !== 32'h1000_0003 || pc_d !== 32'h300C || pc8_d !== 32'h3014 || bd_d !== 1'b1) begin errors++; $display("[TB] FAIL stall_ifid[%0d] got %h/%h/%h/%b exp 10000003/300c/3014/1", i, ir_d, pc_d, pc8_d, bd_d); end
    end
    stall = 0;
    step();
    clear_inputs();
    checks++; if (pc_f !== 32'h3200) begin errors++; $display("[TB] FAIL stall_release_pc_f got %h exp %h", pc_f, 32'h3200); end
    checks++; if (ir_d !== 32'h1000_0040 || pc_d !== 32'h3100 || bd_d !== 1'b0) begin errors++; $display("[TB] FAIL stall_release_ifid got %h/%h/%b exp 10000040/3100/0", ir_d, pc_d, bd_d); end
  endtask

  task automatic test_exc_over_eret();
    stall = 1; exc_req = 1; eret_req = 1; epc = 32'h3ABC; br_taken = 1; br_target = 32'h3300;
    step();
    clear_inputs();
    checks++; if (pc_f !== 32'h4180) begin errors++; $display("[TB] FAIL exc_pc_f got %h exp %h", pc_f, 32'h4180); end
    checks++; if (ir_d !== 32'h0 || pc_d !== 32'h0 || pc8_d !== 32'h0 || exc_d !== 1'b0 || bd_d !== 1'b0) begin errors++; $display("[TB] FAIL exc_flush got %h/%h/%h/%b/%b exp all 0", ir_d, pc_d, pc8_d, exc_d, bd_d); end
    step();
    checks++; if (ir_d !== 32'h1000_0460 || pc_d !== 32'h4180 || pc8_d !== 32'h4188 || pc_f !== 32'h4184) begin errors++; $display("[TB] FAIL handler_fetch got %h/%h/%h/%h exp 10000460/4180/4188/4184", ir_d, pc_d, pc8_d, pc_f); end
  endtask

  task automatic test_eret();
    eret_req = 1; epc = 32'h3ABC;
    step();
    clear_inputs();
    checks++; if (pc_f !== 32'h3ABC || ir_d !== 32'h0 || pc_d !== 32'h0) begin errors++; $display("[TB] FAIL eret_flush got %h/%h/%h exp 3abc/0/0", pc_f, ir_d, pc_d); end
    step();
    checks++; if (ir_d !== 32'h1000_02AF || exc_d !== 1'b0 || pc_d !== 32'h3ABC || pc_f !== 32'h3AC0) begin errors++; $display("[TB] FAIL eret_fetch got %h/%b/%h/%h exp 100002af/0/3abc/3ac0", ir_d, exc_d, pc_d, pc_f); end
  endtask

  task automatic test_fetch_fault();
    // Misaligned fetch inside IM, fetched as a delay slot.
    eret_req = 1; epc = 32'h3ABE;
    step();
    clear_inputs();
    bd_next = 1;
    step();
    bd_next = 0;
    checks++; if (exc_d !== 1'b1 || exccode_d !== 5'd4 || ir_d !== 32'h0) begin errors++; $display("[TB] FAIL misalign_exc got %b/%h/%h exp 1/04/0", exc_d, exccode_d, ir_d); end
    checks++; if (pc_d !== 32'h3ABE || pc8_d !== 32'h3AC6 || bd_d !== 1'b1 || pc_f !== 32'h3AC2) begin errors++; $display("[TB] FAIL misalign_pc got %h/%h/%b/%h exp 3abe/3ac6/1/3ac2", pc_d, pc8_d, bd_d, pc_f); end
    // First word past IM.
    eret_req = 1; epc = 32'h5000;
    step();
    clear_inputs();
    step();
    checks++; if (exc_d !== 1'b1 || exccode_d !== 5'd4 || ir_d !== 32'h0 || pc_d !== 32'h5000 || pc8_d !== 32'h5008) begin errors++; $display("[TB] FAIL above_im got %b/%h/%h/%h/%h exp 1/04/0/5000/5008", exc_d, exccode_d, ir_d, pc_d, pc8_d); end
    // Last word below IM.
    eret_req = 1; epc = 32'h2FFC;
    step();
    clear_inputs();
    step();
    checks++; if (exc_d !== 1'b1 || exccode_d !== 5'd4 || pc_d !== 32'h2FFC) begin errors++; $display("[TB] FAIL below_im got %b/%h/%h exp 1/04/2ffc", exc_d, exccode_d, pc_d); end
    // Last legal word.
    eret_req = 1; epc = 32'h4FFC;
    step();
    clear_inputs();
    step();
    checks++; if (exc_d !== 1'b0 || exccode_d !== 5'd0 || ir_d !== 32'h1000_07FF || pc_f !== 32'h5000) begin errors++; $display("[TB] FAIL last_word got %b/%h/%h/%h exp 0/00/100007ff/5000", exc_d, exccode_d, ir_d, pc_f); end
    // PC arithmetic wraps modulo 2^32.
    eret_req = 1; epc = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    step();
    checks++; if (pc_f !== 32'h0 || pc8_d !== 32'h4 || pc_d !== 32'hFFFF_FFFC || exc_d !== 1'b1) begin errors++; $display("[TB] FAIL wrap got %h/%h/%h/%b exp 0/4/fffffffc/1", pc_f, pc8_d, pc_d, exc_d); end
  endtask

  task automatic test_reset_mid_redirect();
    reset_n = 0; br_taken = 1; br_target = 32'h3800; exc_req = 1; stall = 1;
    step();
    clear_inputs();
    checks++; if (pc_f !== 32'h3000) begin errors++; $display("[TB] FAIL rst_mid_pc_f got %h exp %h", pc_f, 32'h3000); end
    checks++; if (ir_d !== 32'h0 || pc_d !== 32'h0 || pc8_d !== 32'h0 || bd_d !== 1'b0 || exc_d !== 1'b0 || exccode_d !== 5'd0) begin errors++; $display("[TB] FAIL rst_mid_ifid got %h/%h/%h/%b/%b/%h exp all 0", ir_d, pc_d, pc8_d, bd_d, exc_d, exccode_d); end
    reset_n = 1;
    step();
    checks++; if (pc_f !== 32'h3004 || ir_d !== 32'h1000_0000) begin errors++; $display("[TB] FAIL rst_mid_resume got %h/%h exp 3004/10000000", pc_f, ir_d); end
  endtask

  initial begin
    reset_n = 0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_exc_over_eret();
    test_eret();
    test_fetch_fault();
    test_reset_mid_redirect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
